// File: rtl/vu_vxu_cmd_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// vu_vxu_cmd_dispatch_pkg
// Shared XCMD opcode constants and opcode-class decode helpers for the
// scalar-core to VXU command path.
// ----------------------------------------------------------------------------
package vu_vxu_cmd_dispatch_pkg;

    localparam int OPC_W = 8;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t CMD_VVCFGIVL  = 8'h00;
    localparam opcode_t CMD_VSETVL    = 8'h01;
    localparam opcode_t CMD_VF        = 8'h02;
    localparam opcode_t CMD_VMVV      = 8'h10;
    localparam opcode_t CMD_VMSV      = 8'h11;
    localparam opcode_t CMD_FENCE_L_V  = 8'h20;
    localparam opcode_t CMD_FENCE_G_V  = 8'h21;
    localparam opcode_t CMD_FENCE_L_CV = 8'h22;
    localparam opcode_t CMD_FENCE_G_CV = 8'h23;

    // Opcodes whose command carries a companion XIMM word.
    function automatic logic opc_has_imm(input opcode_t op);
        logic r;
        case (op)
            CMD_VVCFGIVL, CMD_VSETVL, CMD_VF, CMD_VMSV: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic opc_is_fence(input opcode_t op);
        logic r;
        case (op)
            CMD_FENCE_L_V, CMD_FENCE_G_V,
            CMD_FENCE_L_CV, CMD_FENCE_G_CV: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vu_vxu_cmd_dispatch_fence_counter.sv
// ----------------------------------------------------------------------------
// vu_fence_counter
// Saturating up/down counter of outstanding vector fences.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_inc, i_dec   : count up / count down (both together = no change)
//   o_count        : current count
//   o_full         : count == MAX
//   o_nonzero      : count != 0
// ----------------------------------------------------------------------------
module vu_fence_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_full,
    output logic         o_nonzero
);

    logic [W-1:0] r_count;

    // Saturates at both ends; a decrement at zero is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != W'(MAX))) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_full    = (r_count == W'(MAX));
    assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/vu_vxu_cmd_dispatch.sv
// ----------------------------------------------------------------------------
// vu_vxu_cmd_dispatch
// Stages one scalar-core vector command (plus optional immediate) and pushes
// it onto the independent vxu_cmdq / vxu_immq ready/valid queues. Tracks
// outstanding vector fences so the core can stall on them.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cpu_cmd_val/rdy/bits, imm    : command input from the scalar core
//   vxu_cmdq_val/rdy/bits        : command queue output
//   vxu_immq_val/rdy/bits        : immediate queue output
//   fence_done                   : one-cycle pulse, one fence retired
//   fence_pending                : outstanding fence count != 0
//   dispatch_idle                : nothing staged and no fence outstanding
// ----------------------------------------------------------------------------
module vu_vxu_cmd_dispatch
    import vu_vxu_cmd_dispatch_pkg::*;
#(
    parameter int CMD_W     = 20,
    parameter int IMM_W     = 64,
    parameter int FENCE_MAX = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_cmd_val,
    output logic             cpu_cmd_rdy,
    input  logic [CMD_W-1:0] cpu_cmd_bits,
    input  logic [IMM_W-1:0] cpu_imm_bits,
    output logic             vxu_cmdq_val,
    input  logic             vxu_cmdq_rdy,
    output logic [CMD_W-1:0] vxu_cmdq_bits,
    output logic             vxu_immq_val,
    input  logic             vxu_immq_rdy,
    output logic [IMM_W-1:0] vxu_immq_bits,
    input  logic             fence_done,
    output logic             fence_pending,
    output logic             dispatch_idle
);

    localparam int CNT_W = $clog2(FENCE_MAX + 1);

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_BOTH     = 2'd1;
    localparam logic [1:0] S_CMD_OWED = 2'd2;
    localparam logic [1:0] S_IMM_OWED = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CMD_W-1:0] r_cmd;
    logic [IMM_W-1:0] r_imm;

    opcode_t    w_in_opc;
    opcode_t    w_stg_opc;
    logic       w_in_has_imm;
    logic       w_in_fence;
    logic       w_stg_fence;
    logic       w_cmd_owed;
    logic       w_imm_owed;
    logic       w_cmd_hs;
    logic       w_imm_hs;
    logic       w_finishing;
    logic       w_accept;
    logic       w_fence_block;
    logic [CNT_W-1:0] w_fence_cnt;
    logic       w_fence_full;
    logic       w_fence_nonzero;

    assign w_in_opc     = cpu_cmd_bits[CMD_W-1 -: OPC_W];
    assign w_stg_opc    = r_cmd[CMD_W-1 -: OPC_W];
    assign w_in_has_imm = opc_has_imm(w_in_opc);
    assign w_in_fence   = opc_is_fence(w_in_opc);
    assign w_stg_fence  = opc_is_fence(w_stg_opc);

    // Valids are pure state decodes, so there is no rdy->val path.
    assign w_cmd_owed = (r_state == S_BOTH) || (r_state == S_CMD_OWED);
    assign w_imm_owed = (r_state == S_BOTH) || (r_state == S_IMM_OWED);
    assign w_cmd_hs   = w_cmd_owed && vxu_cmdq_rdy;
    assign w_imm_hs   = w_imm_owed && vxu_immq_rdy;

    assign w_finishing = (r_state != S_EMPTY) &&
                         (!w_cmd_owed || w_cmd_hs) &&
                         (!w_imm_owed || w_imm_hs);

    // A staged fence enqueueing this cycle lands in the counter at the same
    // edge a newly accepted fence would be staged, so treat one below the
    // limit as full in that case; otherwise the new fence could overflow.
    assign w_fence_block = w_fence_full ||
                           ((w_fence_cnt == CNT_W'(FENCE_MAX - 1)) && w_cmd_hs && w_stg_fence);

    assign cpu_cmd_rdy = ((r_state == S_EMPTY) || w_finishing) && !(w_in_fence && w_fence_block);
    assign w_accept    = cpu_cmd_val && cpu_cmd_rdy;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_in_has_imm ? S_BOTH : S_CMD_OWED;
        end else begin
            case (r_state)
                S_BOTH: begin
                    if (w_cmd_hs && w_imm_hs) w_state_nxt = S_EMPTY;
                    else if (w_cmd_hs)        w_state_nxt = S_IMM_OWED;
                    else if (w_imm_hs)        w_state_nxt = S_CMD_OWED;
                end
                S_CMD_OWED: if (w_cmd_hs) w_state_nxt = S_EMPTY;
                S_IMM_OWED: if (w_imm_hs) w_state_nxt = S_EMPTY;
                default:    w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_cmd   <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cmd <= cpu_cmd_bits;
                if (w_in_has_imm) r_imm <= cpu_imm_bits;
            end
        end
    end

    // Fences are counted when they reach the queue, not at cpu accept.
    vu_fence_counter #(
        .MAX (FENCE_MAX),
        .W   (CNT_W)
    ) u_fence_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_inc     (w_cmd_hs && w_stg_fence),
        .i_dec     (fence_done),
        .o_count   (w_fence_cnt),
        .o_full    (w_fence_full),
        .o_nonzero (w_fence_nonzero)
    );

    assign vxu_cmdq_val  = w_cmd_owed;
    assign vxu_immq_val  = w_imm_owed;
    assign vxu_cmdq_bits = r_cmd;
    assign vxu_immq_bits = r_imm;
    assign fence_pending = w_fence_nonzero;
    assign dispatch_idle = (r_state == S_EMPTY) && !w_fence_nonzero;

endmodule

// File: tb/tb_vu_vxu_cmd_dispatch.sv
module tb_vu_vxu_cmd_dispatch;
    import vu_vxu_cmd_dispatch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cpu_cmd_val;
    logic        cpu_cmd_rdy;
    logic [19:0] cpu_cmd_bits;
    logic [63:0] cpu_imm_bits;
    logic        vxu_cmdq_val;
    logic        vxu_cmdq_rdy;
    logic [19:0] vxu_cmdq_bits;
    logic        vxu_immq_val;
    logic        vxu_immq_rdy;
    logic [63:0] vxu_immq_bits;
    logic        fence_done;
    logic        fence_pending;
    logic        dispatch_idle;

    int n_cmp = 0;
    int n_err = 0;

    vu_vxu_cmd_dispatch #(.CMD_W(20), .IMM_W(64), .FENCE_MAX(7)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_cmd_val   (cpu_cmd_val),
        .cpu_cmd_rdy   (cpu_cmd_rdy),
        .cpu_cmd_bits  (cpu_cmd_bits),
        .cpu_imm_bits  (cpu_imm_bits),
        .vxu_cmdq_val  (vxu_cmdq_val),
        .vxu_cmdq_rdy  (vxu_cmdq_rdy),
        .vxu_cmdq_bits (vxu_cmdq_bits),
        .vxu_immq_val  (vxu_immq_val),
        .vxu_immq_rdy  (vxu_immq_rdy),
        .vxu_immq_bits (vxu_immq_bits),
        .fence_done    (fence_done),
        .fence_pending (fence_pending),
        .dispatch_idle (dispatch_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Independent reference for which opcodes carry an immediate.
    function automatic logic ref_has_imm(input logic [7:0] op);
        return (op == 8'h00) || (op == 8'h01) || (op == 8'h02) || (op == 8'h11);
    endfunction

    typedef struct {
        logic        val;
        logic [19:0] cmd;
        logic [63:0] imm;
        logic        cq_rdy;
        logic        iq_rdy;
        logic        e_rdy;
        logic        e_cv;
        logic [19:0] e_cb;
        logic        e_iv;
        logic [63:0] e_ib;
        logic        e_idle;
    } vec_t;

    function automatic vec_t v(input logic val, input logic [19:0] cmd, input logic [63:0] imm,
                               input logic cq, input logic iq, input logic erdy,
                               input logic ecv, input logic [19:0] ecb,
                               input logic eiv, input logic [63:0] eib, input logic eidle);
        vec_t t;
        t.val = val; t.cmd = cmd; t.imm = imm; t.cq_rdy = cq; t.iq_rdy = iq;
        t.e_rdy = erdy; t.e_cv = ecv; t.e_cb = ecb; t.e_iv = eiv; t.e_ib = eib; t.e_idle = eidle;
        return t;
    endfunction

    vec_t tbl[26];

    logic [19:0] q_cmd[$];
    logic [63:0] q_imm[$];

    initial begin
        int n_acc;
        int sent;
        int cyc;
        logic acc;
        logic [7:0] ops[6];
        logic [7:0] op;
        logic [19:0] exp_c;
        logic [63:0] exp_i;

        // row: val cmd imm cq iq | rdy cv cb iv ib idle
        tbl[0]  = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[1]  = v(1, 20'h01123, 64'h40,          1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[2]  = v(0, 20'h00000, 64'h0,           1, 1, 1, 1, 20'h01123, 1, 64'h40,          0);
        tbl[3]  = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[4]  = v(1, 20'h02abc, 64'h8000_1000,   1, 0, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[5]  = v(0, 20'h00000, 64'h0,           1, 0, 0, 1, 20'h02abc, 1, 64'h8000_1000,   0);
        tbl[6]  = v(0, 20'h00000, 64'h0,           1, 0, 0, 0, 20'h0,     1, 64'h8000_1000,   0);
        tbl[7]  = v(0, 20'h00000, 64'h0,           1, 0, 0, 0, 20'h0,     1, 64'h8000_1000,   0);
        tbl[8]  = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     1, 64'h8000_1000,   0);
        tbl[9]  = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[10] = v(1, 20'h10555, 64'hdead,        0, 0, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[11] = v(0, 20'h00000, 64'h0,           0, 1, 0, 1, 20'h10555, 0, 64'h0,           0);
        tbl[12] = v(0, 20'h00000, 64'h0,           1, 1, 1, 1, 20'h10555, 0, 64'h0,           0);
        tbl[13] = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[14] = v(1, 20'h00777, 64'h5,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[15] = v(1, 20'h11001, 64'h9,           1, 1, 1, 1, 20'h00777, 1, 64'h5,           0);
        tbl[16] = v(0, 20'h00000, 64'h0,           1, 1, 1, 1, 20'h11001, 1, 64'h9,           0);
        tbl[17] = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[18] = v(1, 20'hFF000, 64'h7,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[19] = v(0, 20'h00000, 64'h0,           1, 1, 1, 1, 20'hFF000, 0, 64'h0,           0);
        tbl[20] = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[21] = v(1, 20'h02001, 64'h3,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);
        tbl[22] = v(0, 20'h00000, 64'h0,           0, 1, 0, 1, 20'h02001, 1, 64'h3,           0);
        tbl[23] = v(0, 20'h00000, 64'h0,           0, 1, 0, 1, 20'h02001, 0, 64'h0,           0);
        tbl[24] = v(0, 20'h00000, 64'h0,           1, 1, 1, 1, 20'h02001, 0, 64'h0,           0);
        tbl[25] = v(0, 20'h00000, 64'h0,           1, 1, 1, 0, 20'h0,     0, 64'h0,           1);

        reset_n = 1'b0;
        cpu_cmd_val = 1'b0; cpu_cmd_bits = '0; cpu_imm_bits = '0;
        vxu_cmdq_rdy = 1'b1; vxu_immq_rdy = 1'b1; fence_done = 1'b0;
        #2;
        chk("reset_cpu_rdy", cpu_cmd_rdy, 1);
        chk("reset_cmdq_val", vxu_cmdq_val, 0);
        chk("reset_immq_val", vxu_immq_val, 0);
        chk("reset_pending", fence_pending, 0);
        chk("reset_idle", dispatch_idle, 1);
        chk("reset_cmd_bits", vxu_cmdq_bits, 0);
        chk("reset_imm_bits", vxu_immq_bits, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven directed vectors ----------------
        for (int i = 0; i < 26; i++) begin
            cpu_cmd_val  = tbl[i].val;
            cpu_cmd_bits = tbl[i].cmd;
            cpu_imm_bits = tbl[i].imm;
            vxu_cmdq_rdy = tbl[i].cq_rdy;
            vxu_immq_rdy = tbl[i].iq_rdy;
            @(negedge clk);
            chk($sformatf("row%0d_cpu_rdy", i), cpu_cmd_rdy, tbl[i].e_rdy);
            chk($sformatf("row%0d_cmdq_val", i), vxu_cmdq_val, tbl[i].e_cv);
            chk($sformatf("row%0d_immq_val", i), vxu_immq_val, tbl[i].e_iv);
            if (tbl[i].e_cv) chk($sformatf("row%0d_cmdq_bits", i), vxu_cmdq_bits, tbl[i].e_cb);
            if (tbl[i].e_iv) chk($sformatf("row%0d_immq_bits", i), vxu_immq_bits, tbl[i].e_ib);
            chk($sformatf("row%0d_idle", i), dispatch_idle, tbl[i].e_idle);
            chk($sformatf("row%0d_pending", i), fence_pending, 0);
            @(posedge clk); #1;
        end

        // ---------------- fence fill to the limit ----------------
        cpu_cmd_val = 1'b1; cpu_cmd_bits = {CMD_FENCE_G_V, 12'h000}; cpu_imm_bits = '0;
        vxu_cmdq_rdy = 1'b1; vxu_immq_rdy = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_cmd_rdy) n_acc++;
            @(posedge clk); #1;
        end
        chk("fence_accept_count", 64'(n_acc), 7);
        @(negedge clk);
        chk("fence_8th_stall", cpu_cmd_rdy, 0);
        chk("fence_full_pending", fence_pending, 1);
        chk("fence_full_idle", dispatch_idle, 0);
        chk("fence_full_cmdq_val", vxu_cmdq_val, 0);
        cpu_cmd_val = 1'b0; cpu_cmd_bits = {CMD_VMVV, 12'h000};
        #1;
        chk("nonfence_rdy_when_full", cpu_cmd_rdy, 1);
        @(posedge clk); #1;

        // retire one while a fence waits: still blocked this cycle
        cpu_cmd_val = 1'b1; cpu_cmd_bits = {CMD_FENCE_G_V, 12'h008};
        vxu_cmdq_rdy = 1'b0; fence_done = 1'b1;
        @(negedge clk);
        chk("fence_done_same_cycle_rdy", cpu_cmd_rdy, 0);
        @(posedge clk); #1;
        fence_done = 1'b0;
        @(negedge clk);
        chk("fence_after_done_rdy", cpu_cmd_rdy, 1);
        @(posedge clk); #1;
        // enqueue the staged fence together with a fence_done: count unchanged (6)
        cpu_cmd_val = 1'b0; vxu_cmdq_rdy = 1'b1; fence_done = 1'b1;
        @(negedge clk);
        chk("fence_inc_dec_cmdq_val", vxu_cmdq_val, 1);
        @(posedge clk); #1;
        fence_done = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            fence_done = 1'b1;
            @(posedge clk); #1;
            fence_done = 1'b0;
            @(negedge clk);
            chk($sformatf("fence_drain_%0d_pending", k), fence_pending, (k < 6) ? 1 : 0);
        end
        chk("fence_drained_idle", dispatch_idle, 1);
        @(posedge clk); #1;

        // ---------------- random-ready mixed stream ----------------
        ops[0] = CMD_VVCFGIVL; ops[1] = CMD_VSETVL; ops[2] = CMD_VF;
        ops[3] = CMD_VMSV;     ops[4] = CMD_VMVV;   ops[5] = 8'hFF;
        sent = 0; cyc = 0;
        cpu_cmd_val = 1'b0;
        while ((sent < 16 || q_cmd.size() != 0 || q_imm.size() != 0) && cyc < 400) begin
            if (!cpu_cmd_val && sent < 16 && $urandom_range(0, 3) != 0) begin
                op = ops[$urandom_range(0, 5)];
                cpu_cmd_bits = {op, 12'(sent)};
                cpu_imm_bits = {32'(sent), 32'hA5A5_0000 | 32'(sent)};
                cpu_cmd_val  = 1'b1;
            end
            vxu_cmdq_rdy = 1'($urandom_range(0, 1));
            vxu_immq_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = 1'b0;
            if (vxu_cmdq_val && vxu_cmdq_rdy) begin
                exp_c = (q_cmd.size() != 0) ? q_cmd.pop_front() : 20'hxxxxx;
                chk("stream_cmd", vxu_cmdq_bits, exp_c);
            end
            if (vxu_immq_val && vxu_immq_rdy) begin
                exp_i = (q_imm.size() != 0) ? q_imm.pop_front() : 64'hx;
                chk("stream_imm", vxu_immq_bits, exp_i);
            end
            if (cpu_cmd_val && cpu_cmd_rdy) begin
                q_cmd.push_back(cpu_cmd_bits);
                if (ref_has_imm(cpu_cmd_bits[19:12])) q_imm.push_back(cpu_imm_bits);
                sent++;
                acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) cpu_cmd_val = 1'b0;
            cyc++;
        end
        chk("stream_complete", ((sent == 16) && q_cmd.size() == 0 && q_imm.size() == 0) ? 1 : 0, 1);
        chk("stream_end_idle", dispatch_idle, 1);

        // ---------------- asynchronous reset while in BOTH ----------------
        cpu_cmd_val = 1'b1; cpu_cmd_bits = {CMD_FENCE_L_V, 12'h001};
        vxu_cmdq_rdy = 1'b1; vxu_immq_rdy = 1'b1;
        @(posedge clk); #1;
        cpu_cmd_val = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_pending", fence_pending, 1);
        @(posedge clk); #1;
        cpu_cmd_val = 1'b1; cpu_cmd_bits = {CMD_VF, 12'h0F0}; cpu_imm_bits = 64'h1234;
        vxu_cmdq_rdy = 1'b0; vxu_immq_rdy = 1'b0;
        @(posedge clk); #1;
        cpu_cmd_val = 1'b0;
        @(negedge clk);
        chk("pre_reset_cmdq_val", vxu_cmdq_val, 1);
        chk("pre_reset_immq_val", vxu_immq_val, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_cmdq_val", vxu_cmdq_val, 0);
        chk("async_reset_immq_val", vxu_immq_val, 0);
        chk("async_reset_pending", fence_pending, 0);
        chk("async_reset_idle", dispatch_idle, 1);
        chk("async_reset_cpu_rdy", cpu_cmd_rdy, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", dispatch_idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
